// File: rtl/param_mem_arbiter.sv
// Two-requester arbiter that serialises req/gnt transactions onto one single-port sync memory.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN to make port A always win ties.
module param_mem_arbiter #(
    parameter int unsigned SIZE   = 256,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [WIDTH-1:0]  rdata,
    output logic              addr_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRdResp
    } state_e;

    state_e            state_q, state_d;
    logic              win_b_q, win_b_d;   // 1 = current transaction belongs to port B
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              pick_b;
    logic [ADDR_W-1:0] addr_sel;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_b_q, last_b_d;
`endif

    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick_b = !req_a;
`else
        // On a tie, B wins only if A was granted last.
        pick_b = req_b && (!req_a || !last_b_q);
`endif
        addr_sel = pick_b ? addr_b : addr_a;
    end

    always_comb begin
        state_d  = state_q;
        win_b_d  = win_b_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_b_d = last_b_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    win_b_d  = pick_b;
                    we_d     = pick_b ? we_b : we_a;
                    addr_d   = addr_sel;
                    wdata_d  = pick_b ? wdata_b : wdata_a;
                    err_d    = (32'(addr_sel) >= SIZE);
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_b_d = pick_b;
`endif
                    state_d  = StAccess;
                end
            end
            StAccess: state_d = we_q ? StIdle : StRdResp;
            StRdResp: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            win_b_q  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b_q <= last_b_d;
`endif
        end
    end

    always_comb begin
        gnt_a     = (state_q == StAccess) && !win_b_q;
        gnt_b     = (state_q == StAccess) && win_b_q;
        addr_err  = (state_q == StAccess) && err_q;
        mem_we    = (state_q == StAccess) && we_q && !err_q;
        rvalid_a  = (state_q == StRdResp) && !win_b_q;
        rvalid_b  = (state_q == StRdResp) && win_b_q;
        // Out-of-range reads return zero rather than whatever the memory aliases to.
        rdata     = ((state_q == StRdResp) && !err_q) ? mem_rdata : '0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_param_mem_arbiter.sv
// Directed bench for param_mem_arbiter with a registered-read memory model (SIZE=256, ADDR_W=9).
`timescale 1ns/1ps
module tb_param_mem_arbiter;

    localparam int unsigned SIZE   = 256;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_a, we_a, req_b, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [WIDTH-1:0]  wdata_a, wdata_b;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b, addr_err, mem_we;
    logic [WIDTH-1:0]  rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mem [0:SIZE-1];
    logic             bad_wr;
    logic [WIDTH-1:0] model [0:7];

    always #5 clk = ~clk;

    param_mem_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata(rdata), .addr_err(addr_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port memory; out-of-range addresses read back a junk pattern.
    always @(posedge clk) begin
        if (reset) bad_wr <= 1'b0;
        else if (mem_we && (32'(mem_addr) >= SIZE)) bad_wr <= 1'b1;
        if (mem_we && (32'(mem_addr) < SIZE)) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= (32'(mem_addr) < SIZE) ? mem[mem_addr[7:0]] : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge; the request is sampled on the next posedge.
    task automatic txn(input logic port_b, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] exp_rd,
                       input logic exp_err);
        if (port_b) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        @(negedge clk);
        check("gnt_a", 32'(gnt_a), 32'(!port_b));
        check("gnt_b", 32'(gnt_b), 32'(port_b));
        check("addr_err", 32'(addr_err), 32'(exp_err));
        check("mem_we", 32'(mem_we), 32'(we && !exp_err));
        check("mem_addr", 32'(mem_addr), 32'(addr));
        req_a = 1'b0;
        req_b = 1'b0;
        if (!we) begin
            @(negedge clk);
            check("rvalid_a", 32'(rvalid_a), 32'(!port_b));
            check("rvalid_b", 32'(rvalid_b), 32'(port_b));
            check("rdata", 32'(rdata), 32'(exp_rd));
            check("rd_mem_we", 32'(mem_we), 32'd0);
        end
        @(negedge clk);
        check("idle_gnt", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] order;
        logic [3:0] exp_order;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
        @(negedge clk);
        do_reset();

        check("rst_outs", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, addr_err, mem_we}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Write A then read back through B.
        txn(1'b0, 1'b1, 9'h010, 8'hA5, 8'h00, 1'b0);
        check("hold_addr", 32'(mem_addr), 32'h10);
        check("hold_wdata", 32'(mem_wdata), 32'hA5);
        txn(1'b1, 1'b0, 9'h010, 8'h00, 8'hA5, 1'b0);

        // Read-after-write, A writes then B reads.
        txn(1'b0, 1'b1, 9'h020, 8'h3C, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 9'h020, 8'h00, 8'h3C, 1'b0);

        // Out-of-range read and write at 300.
        txn(1'b0, 1'b0, 9'd300, 8'h00, 8'h00, 1'b1);
        txn(1'b0, 1'b1, 9'd300, 8'h77, 8'h00, 1'b1);
        check("no_oor_write", 32'(bad_wr), 32'd0);

        // Reset during ACCESS of a read drops the transaction.
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'h010;
        @(negedge clk);
        check("pre_rst_gnt", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_drop", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_we}), 32'd0);
        @(negedge clk);
        check("rst_drop2", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_we}), 32'd0);

        // Both ports hold write requests from reset; record 4 grant winners.
        do_reset();
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'h030; wdata_a = 8'h11;
        req_b = 1'b1; we_b = 1'b1; addr_b = 9'h031; wdata_b = 8'h22;
        order = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tie_one_gnt", 32'(gnt_a ^ gnt_b), 32'd1);
            order[i] = gnt_b;
            @(negedge clk);
        end
        req_a = 1'b0; req_b = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;   // A,B,A,B with bit 0 first
`endif
        check("tie_order", 32'(order), 32'(exp_order));
        @(negedge clk);

        // Random mix over a pre-written window, checked against a bench model.
        for (int i = 0; i < 8; i++) begin
            model[i] = 8'(i * 37 + 5);
            txn(i[0], 1'b1, 9'(i), model[i], 8'h00, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            logic       pb;
            logic       w;
            logic [2:0] a;
            logic [7:0] d;
            pb = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 255));
            if (w) begin
                model[a] = d;
                txn(pb, 1'b1, 9'(a), d, 8'h00, 1'b0);
            end else begin
                txn(pb, 1'b0, 9'(a), 8'h00, model[a], 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
